// File: rtl/configurable_delay_line_if.sv
// Sample-stream bundle for the configurable delay line: control and data in,
// delayed sample, validity and fill level out.
interface configurable_delay_line_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  shift_en;
  logic                  clear;
  logic [DATA_WIDTH-1:0] d;
  logic [ADDR_WIDTH-1:0] length;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic [ADDR_WIDTH-1:0] fill_level;

  modport master (
    output shift_en, clear, d, length,
    input  q, q_valid, fill_level
  );

  modport slave (
    input  shift_en, clear, d, length,
    output q, q_valid, fill_level
  );
endinterface

// File: rtl/configurable_delay_line.sv
// Runtime-configurable delay line built on a circular buffer; a length change
// flushes the line but keeps the write pointer, while clear also rewinds it.
module configurable_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  configurable_delay_line_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] length_q;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  valid_q, valid_d;

  logic [ADDR_WIDTH-1:0] eff_len_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  len_change_s;
  logic                  accept_s;

  // Effective delay and read-side data; L=1 bypasses the memory entirely.
  always_comb begin
    len_change_s = (bus.length != length_q);
    accept_s     = bus.shift_en && !bus.clear;
    eff_len_s    = (bus.length == '0) ? ONE : bus.length;
    rd_addr_s    = wr_ptr_q - (eff_len_s - ONE);
    if (eff_len_s == ONE) begin
      rd_data_s = bus.d;
    end else begin
      rd_data_s = mem_q[rd_addr_s];
    end
  end

  // Next-state selection: clear, then length change, then shift, then hold.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    q_d      = q_q;
    valid_d  = valid_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      q_d      = '0;
      valid_d  = 1'b0;
    end else if (len_change_s) begin
      if (bus.shift_en) begin
        wr_ptr_d = wr_ptr_q + ONE;
        fill_d   = ONE;
        valid_d  = (eff_len_s == ONE);
        q_d      = (eff_len_s == ONE) ? bus.d : '0;
      end else begin
        fill_d  = '0;
        q_d     = '0;
        valid_d = 1'b0;
      end
    end else if (bus.shift_en) begin
      wr_ptr_d = wr_ptr_q + ONE;
      fill_d   = (fill_q < eff_len_s) ? fill_q + ONE : eff_len_s;
      valid_d  = valid_q || (fill_q >= eff_len_s - ONE);
      q_d      = (valid_q || (fill_q >= eff_len_s - ONE)) ? rd_data_s : '0;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      length_q <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      length_q <= bus.length;
      q_q      <= q_d;
      valid_q  <= valid_d;
    end
  end

  // Sample storage; contents survive reset and are masked by q_valid.
  always_ff @(posedge clk) begin
    if (accept_s && !reset) begin
      mem_q[wr_ptr_q] <= bus.d;
    end
  end

  assign bus.q          = q_q;
  assign bus.q_valid    = valid_q;
  assign bus.fill_level = fill_q;
endmodule
